// File: rtl/load_store_stage_if.sv
// Data-memory request/response bus between the load/store stage (master) and data memory (slave).
// One outstanding request at a time; dmem_err is meaningful only while dmem_ack is high.
interface load_store_stage_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [63:0] dmem_addr;
    logic [63:0] dmem_wdata;
    logic [7:0]  dmem_wstrb;
    logic [63:0] dmem_rdata;
    logic        dmem_ack;
    logic        dmem_err;

    modport master (
        output dmem_req,
        output dmem_we,
        output dmem_addr,
        output dmem_wdata,
        output dmem_wstrb,
        input  dmem_rdata,
        input  dmem_ack,
        input  dmem_err
    );

    modport slave (
        input  dmem_req,
        input  dmem_we,
        input  dmem_addr,
        input  dmem_wdata,
        input  dmem_wstrb,
        output dmem_rdata,
        output dmem_ack,
        output dmem_err
    );
endinterface

// File: rtl/load_store_stage.sv
// Memory pipeline stage: issues aligned loads/stores on the data bus, formats load data and
// drives the registered writeback latch plus alignment/access-fault flags.
module load_store_stage (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_mem_v,
    input  logic [31:0]               i_mem_ir,
    input  logic [63:0]               i_mem_npc,
    input  logic [63:0]               i_mem_alu_result,
    input  logic [63:0]               i_mem_sr2,
    input  logic [4:0]                i_mem_drid,
    input  logic                      i_wb_stall,
    output logic                      o_mem_stall,
    load_store_stage_if.master        dmem,
    output logic                      o_wb_v,
    output logic [31:0]               o_wb_ir,
    output logic [63:0]               o_wb_npc,
    output logic [63:0]               o_wb_alu_result,
    output logic [63:0]               o_wb_mem_result,
    output logic [4:0]                o_wb_drid,
    output logic                      o_mem_lam,
    output logic                      o_mem_laf,
    output logic                      o_mem_sam,
    output logic                      o_mem_saf
);

    localparam logic [6:0] OpLoad  = 7'b0000011;
    localparam logic [6:0] OpStore = 7'b0100011;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StHold
    } state_e;

    state_e r_state;
    state_e w_state_nxt;

    // Shift the addressed bytes down to lane 0, then truncate and extend by access size.
    function automatic logic [63:0] format_load(input logic [63:0] rdata, input logic [2:0] off,
                                                input logic [2:0] funct3);
        logic [63:0] shifted;
        logic [63:0] result;
        shifted = rdata >> {off, 3'b000};
        case (funct3[1:0])
            2'd0:    result = funct3[2] ? {56'd0, shifted[7:0]}
                                        : {{56{shifted[7]}}, shifted[7:0]};
            2'd1:    result = funct3[2] ? {48'd0, shifted[15:0]}
                                        : {{48{shifted[15]}}, shifted[15:0]};
            2'd2:    result = funct3[2] ? {32'd0, shifted[31:0]}
                                        : {{32{shifted[31]}}, shifted[31:0]};
            default: result = shifted;
        endcase
        return result;
    endfunction

    // Decode of the instruction presented by execute.
    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic        w_ld_acc;
    logic        w_st_acc;
    logic [7:0]  w_size_mask;
    logic [2:0]  w_align_mask;
    logic        w_misaligned;
    logic        w_issue;
    logic        w_lam;
    logic        w_sam;
    logic [2:0]  w_off;
    logic [7:0]  w_wstrb;
    logic [63:0] w_wdata;

    assign w_opcode = i_mem_ir[6:0];
    assign w_funct3 = i_mem_ir[14:12];
    // funct3 111 loads and funct3[2]=1 stores are not real accesses and simply pass through.
    assign w_ld_acc = (w_opcode == OpLoad) && (w_funct3 != 3'b111);
    assign w_st_acc = (w_opcode == OpStore) && !w_funct3[2];

    always_comb begin
        w_size_mask  = 8'h01;
        w_align_mask = 3'b000;
        case (w_funct3[1:0])
            2'd0: begin
                w_size_mask  = 8'h01;
                w_align_mask = 3'b000;
            end
            2'd1: begin
                w_size_mask  = 8'h03;
                w_align_mask = 3'b001;
            end
            2'd2: begin
                w_size_mask  = 8'h0F;
                w_align_mask = 3'b011;
            end
            default: begin
                w_size_mask  = 8'hFF;
                w_align_mask = 3'b111;
            end
        endcase
    end

    assign w_off        = i_mem_alu_result[2:0];
    assign w_misaligned = |(w_off & w_align_mask);
    assign w_issue      = i_mem_v && (w_ld_acc || w_st_acc) && !w_misaligned;
    assign w_lam        = i_mem_v && w_ld_acc && w_misaligned;
    assign w_sam        = i_mem_v && w_st_acc && w_misaligned;
    assign w_wstrb      = w_size_mask << w_off;
    assign w_wdata      = i_mem_sr2 << {w_off, 3'b000};

    // Bus registers.
    logic        r_dmem_req;
    logic        r_dmem_we;
    logic [63:0] r_dmem_addr;
    logic [63:0] r_dmem_wdata;
    logic [7:0]  r_dmem_wstrb;

    // Copy of the in-flight instruction so completion never depends on execute's outputs.
    logic [31:0] r_pend_ir;
    logic [63:0] r_pend_npc;
    logic [63:0] r_pend_alu;
    logic [4:0]  r_pend_drid;
    logic        r_pend_load;
    logic [2:0]  r_pend_funct3;

    logic [63:0] r_hold_result;
    logic        r_hold_err;

    logic [63:0] w_ld_data;
    logic [63:0] w_ack_result;
    logic [63:0] w_fin_result;
    logic        w_fin_err;

    // Control strobes from the FSM.
    logic w_mem_stall;
    logic w_issue_en;
    logic w_req_clr;
    logic w_hold_cap;
    logic w_wb_load_in;
    logic w_wb_load_ack;
    logic w_wb_load_hold;

    assign w_ld_data    = format_load(dmem.dmem_rdata, r_pend_alu[2:0], r_pend_funct3);
    assign w_ack_result = (r_pend_load && !dmem.dmem_err) ? w_ld_data : 64'd0;
    assign w_fin_result = w_wb_load_hold ? r_hold_result : w_ack_result;
    assign w_fin_err    = w_wb_load_hold ? r_hold_err : dmem.dmem_err;

    always_comb begin
        w_state_nxt    = r_state;
        w_mem_stall    = 1'b0;
        w_issue_en     = 1'b0;
        w_req_clr      = 1'b0;
        w_hold_cap     = 1'b0;
        w_wb_load_in   = 1'b0;
        w_wb_load_ack  = 1'b0;
        w_wb_load_hold = 1'b0;
        case (r_state)
            StIdle: begin
                if (i_wb_stall) begin
                    w_mem_stall = 1'b1;
                end else if (w_issue) begin
                    w_mem_stall = 1'b1;
                    w_issue_en  = 1'b1;
                    w_state_nxt = StWait;
                end else begin
                    w_wb_load_in = 1'b1;
                end
            end
            StWait: begin
                w_mem_stall = !(dmem.dmem_ack && !i_wb_stall);
                if (dmem.dmem_ack) begin
                    w_req_clr = 1'b1;
                    if (i_wb_stall) begin
                        w_hold_cap  = 1'b1;
                        w_state_nxt = StHold;
                    end else begin
                        w_wb_load_ack = 1'b1;
                        w_state_nxt   = StIdle;
                    end
                end
            end
            StHold: begin
                w_mem_stall = i_wb_stall;
                if (!i_wb_stall) begin
                    w_wb_load_hold = 1'b1;
                    w_state_nxt    = StIdle;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    // Execute must see no stall while the stage is held in reset.
    assign o_mem_stall = w_mem_stall && i_rst_n;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_dmem_req   <= 1'b0;
            r_dmem_we    <= 1'b0;
            r_dmem_addr  <= 64'd0;
            r_dmem_wdata <= 64'd0;
            r_dmem_wstrb <= 8'd0;
        end else if (w_issue_en) begin
            r_dmem_req   <= 1'b1;
            r_dmem_we    <= w_st_acc;
            r_dmem_addr  <= {i_mem_alu_result[63:3], 3'b000};
            r_dmem_wdata <= w_wdata;
            r_dmem_wstrb <= w_wstrb;
        end else if (w_req_clr) begin
            r_dmem_req <= 1'b0;
            r_dmem_we  <= 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pend_ir     <= 32'd0;
            r_pend_npc    <= 64'd0;
            r_pend_alu    <= 64'd0;
            r_pend_drid   <= 5'd0;
            r_pend_load   <= 1'b0;
            r_pend_funct3 <= 3'd0;
        end else if (w_issue_en) begin
            r_pend_ir     <= i_mem_ir;
            r_pend_npc    <= i_mem_npc;
            r_pend_alu    <= i_mem_alu_result;
            r_pend_drid   <= i_mem_drid;
            r_pend_load   <= w_ld_acc;
            r_pend_funct3 <= w_funct3;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_hold_result <= 64'd0;
            r_hold_err    <= 1'b0;
        end else if (w_hold_cap) begin
            r_hold_result <= w_ack_result;
            r_hold_err    <= dmem.dmem_err;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_wb_v          <= 1'b0;
            o_wb_ir         <= 32'd0;
            o_wb_npc        <= 64'd0;
            o_wb_alu_result <= 64'd0;
            o_wb_mem_result <= 64'd0;
            o_wb_drid       <= 5'd0;
            o_mem_lam       <= 1'b0;
            o_mem_laf       <= 1'b0;
            o_mem_sam       <= 1'b0;
            o_mem_saf       <= 1'b0;
        end else if (w_wb_load_in) begin
            o_wb_v          <= i_mem_v;
            o_wb_ir         <= i_mem_ir;
            o_wb_npc        <= i_mem_npc;
            o_wb_alu_result <= i_mem_alu_result;
            o_wb_mem_result <= 64'd0;
            o_wb_drid       <= i_mem_drid;
            o_mem_lam       <= w_lam;
            o_mem_laf       <= 1'b0;
            o_mem_sam       <= w_sam;
            o_mem_saf       <= 1'b0;
        end else if (w_wb_load_ack || w_wb_load_hold) begin
            o_wb_v          <= 1'b1;
            o_wb_ir         <= r_pend_ir;
            o_wb_npc        <= r_pend_npc;
            o_wb_alu_result <= r_pend_alu;
            o_wb_mem_result <= w_fin_result;
            o_wb_drid       <= r_pend_drid;
            o_mem_lam       <= 1'b0;
            o_mem_laf       <= r_pend_load && w_fin_err;
            o_mem_sam       <= 1'b0;
            o_mem_saf       <= !r_pend_load && w_fin_err;
        end
    end

    assign dmem.dmem_req   = r_dmem_req;
    assign dmem.dmem_we    = r_dmem_we;
    assign dmem.dmem_addr  = r_dmem_addr;
    assign dmem.dmem_wdata = r_dmem_wdata;
    assign dmem.dmem_wstrb = r_dmem_wstrb;

endmodule

// File: tb/tb_load_store_stage.sv
// Bench for load_store_stage: directed cases plus random loads/stores/ALU ops checked against a
// byte-level reference model; the bench plays the data memory with chosen latency and errors.
module tb_load_store_stage;

    localparam logic [6:0] OpLoad  = 7'b0000011;
    localparam logic [6:0] OpStore = 7'b0100011;
    localparam logic [6:0] OpAlu   = 7'b0110011;

    logic        clk;
    logic        rst_n;
    logic        mem_v;
    logic [31:0] mem_ir;
    logic [63:0] mem_npc;
    logic [63:0] mem_alu;
    logic [63:0] mem_sr2;
    logic [4:0]  mem_drid;
    logic        wb_stall;
    logic        mem_stall;
    logic        wb_v;
    logic [31:0] wb_ir;
    logic [63:0] wb_npc;
    logic [63:0] wb_alu;
    logic [63:0] wb_mem;
    logic [4:0]  wb_drid;
    logic        lam;
    logic        laf;
    logic        sam;
    logic        saf;

    load_store_stage_if ifc ();

    load_store_stage dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_mem_v          (mem_v),
        .i_mem_ir         (mem_ir),
        .i_mem_npc        (mem_npc),
        .i_mem_alu_result (mem_alu),
        .i_mem_sr2        (mem_sr2),
        .i_mem_drid       (mem_drid),
        .i_wb_stall       (wb_stall),
        .o_mem_stall      (mem_stall),
        .dmem             (ifc),
        .o_wb_v           (wb_v),
        .o_wb_ir          (wb_ir),
        .o_wb_npc         (wb_npc),
        .o_wb_alu_result  (wb_alu),
        .o_wb_mem_result  (wb_mem),
        .o_wb_drid        (wb_drid),
        .o_mem_lam        (lam),
        .o_mem_laf        (laf),
        .o_mem_sam        (sam),
        .o_mem_saf        (saf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int n_req = 0;
    logic prev_req = 1'b0;
    int stall_cycles;

    // Expected writeback latch contents.
    logic        e_v;
    logic [31:0] e_ir;
    logic [63:0] e_npc, e_alu, e_mem;
    logic [4:0]  e_drid;
    logic [3:0]  e_flags;

    // Snapshots of the most recent operation for directed literal checks.
    logic [63:0] last_mem, last_addr, last_wdata;
    logic [7:0]  last_wstrb;
    logic        last_we;
    logic [3:0]  last_flags;

    always @(posedge clk) begin
        if (ifc.dmem_req && !prev_req) n_req <= n_req + 1;
        prev_req <= ifc.dmem_req;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk_ir(input logic [6:0] opc, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {17'd0, f3, rd, opc};
    endfunction

    // Pick nbytes bytes starting at byte off, then optionally sign-extend arithmetically.
    function automatic logic [63:0] ref_load(input logic [63:0] rdata, input int off,
                                             input int nbytes, input bit sgn);
        logic [63:0] v;
        v = 64'd0;
        for (int i = 0; i < nbytes; i++)
            v = v + (((rdata >> (8 * (off + i))) & 64'hFF) << (8 * i));
        if (sgn && nbytes < 8 && v >= (64'd1 << (8 * nbytes - 1)))
            v = v - (64'd1 << (8 * nbytes));
        return v;
    endfunction

    task automatic set_exp(input logic v, input logic [31:0] ir, input logic [63:0] npc,
                           input logic [63:0] alu, input logic [63:0] res, input logic [4:0] rd,
                           input logic [3:0] flags);
        e_v = v; e_ir = ir; e_npc = npc; e_alu = alu; e_mem = res; e_drid = rd; e_flags = flags;
    endtask

    task automatic check_wb(input string tag);
        chk({tag, "_wb_v"}, 64'(wb_v), 64'(e_v));
        chk({tag, "_wb_ir"}, 64'(wb_ir), 64'(e_ir));
        chk({tag, "_wb_npc"}, wb_npc, e_npc);
        chk({tag, "_wb_alu"}, wb_alu, e_alu);
        chk({tag, "_wb_mem"}, wb_mem, e_mem);
        chk({tag, "_wb_drid"}, 64'(wb_drid), 64'(e_drid));
        chk({tag, "_flags"}, 64'({lam, laf, sam, saf}), 64'(e_flags));
    endtask

    task automatic idle();
        mem_v = 1'b0; mem_ir = '0; mem_npc = '0; mem_alu = '0; mem_sr2 = '0; mem_drid = '0;
        wb_stall = 1'b0;
        @(posedge clk); #1;
        set_exp(1'b0, '0, '0, '0, '0, '0, 4'b0000);
        chk("idle_wb_v", 64'(wb_v), 64'(e_v));
        chk("idle_wb_mem", wb_mem, e_mem);
    endtask

    // Present one instruction and act as memory: lat empty WAIT cycles, then ACK; hold = cycles
    // (from the ACK cycle on) with WB_STALL high; pre = IDLE cycles stalled before acceptance.
    task automatic run_op(input logic [31:0] ir, input logic [63:0] addr, input logic [63:0] sr2,
                          input logic [63:0] rdata, input int lat, input logic err,
                          input int hold, input int pre);
        logic [2:0]  f3;
        bit          is_ld, is_st, acc, mis, go;
        int          nb, off, req0;
        logic [63:0] npc, res;
        logic [4:0]  rd;
        logic [7:0]  strb;
        f3    = ir[14:12];
        is_ld = (ir[6:0] == OpLoad);
        is_st = (ir[6:0] == OpStore);
        acc   = (is_ld && f3 != 3'b111) || (is_st && !f3[2]);
        nb    = 1 << f3[1:0];
        off   = int'(addr[2:0]);
        mis   = acc && ((addr % 64'(nb)) != 0);
        go    = acc && !mis;
        npc   = {$urandom, $urandom};
        rd    = 5'($urandom);
        strb  = '0;
        for (int i = 0; i < nb; i++) if (off + i < 8) strb[off + i] = 1'b1;
        req0 = n_req;
        stall_cycles = 0;

        mem_v = 1'b1; mem_ir = ir; mem_npc = npc; mem_alu = addr; mem_sr2 = sr2; mem_drid = rd;
        wb_stall = (pre > 0);
        for (int k = 0; k < pre; k++) begin
            @(negedge clk);
            chk("pre_stall", 64'(mem_stall), 64'd1);
            chk("pre_req", 64'(ifc.dmem_req), 64'd0);
            @(posedge clk); #1;
            chk("pre_wb_v", 64'(wb_v), 64'(e_v));
        end
        wb_stall = 1'b0;
        @(negedge clk);
        chk("issue_stall", 64'(mem_stall), 64'(go));
        if (mem_stall) stall_cycles++;
        @(posedge clk); #1;
        if (!go) begin
            set_exp(1'b1, ir, npc, addr, 64'd0, rd, {is_ld && mis, 1'b0, is_st && mis, 1'b0});
            check_wb("pass");
            chk("pass_req", 64'(ifc.dmem_req), 64'd0);
        end else begin
            last_addr = ifc.dmem_addr; last_wdata = ifc.dmem_wdata;
            last_wstrb = ifc.dmem_wstrb; last_we = ifc.dmem_we;
            chk("req", 64'(ifc.dmem_req), 64'd1);
            chk("addr", ifc.dmem_addr, addr & ~64'h7);
            chk("wstrb", 64'(ifc.dmem_wstrb), 64'(strb));
            chk("wdata", ifc.dmem_wdata, sr2 << (8 * off));
            chk("we", 64'(ifc.dmem_we), 64'(is_st));
            for (int k = 0; k < lat; k++) begin
                @(negedge clk);
                chk("wait_stall", 64'(mem_stall), 64'd1);
                if (mem_stall) stall_cycles++;
                @(posedge clk); #1;
                chk("wait_req", 64'(ifc.dmem_req), 64'd1);
                chk("wait_addr", ifc.dmem_addr, addr & ~64'h7);
                check_wb("wait_keep");
            end
            ifc.dmem_ack = 1'b1; ifc.dmem_rdata = rdata; ifc.dmem_err = err;
            wb_stall = (hold > 0);
            @(negedge clk);
            chk("ack_stall", 64'(mem_stall), 64'(hold > 0));
            if (mem_stall) stall_cycles++;
            @(posedge clk); #1;
            ifc.dmem_ack = 1'b0; ifc.dmem_err = 1'b0; ifc.dmem_rdata = {$urandom, $urandom};
            res = (is_st || err) ? 64'd0 : ref_load(rdata, off, nb, !f3[2]);
            if (hold > 0) begin
                chk("hold_req", 64'(ifc.dmem_req), 64'd0);
                check_wb("hold_keep");
                for (int k = 1; k < hold; k++) begin
                    @(negedge clk);
                    chk("hold_stall", 64'(mem_stall), 64'd1);
                    @(posedge clk); #1;
                    check_wb("hold_keep");
                end
                wb_stall = 1'b0;
                @(negedge clk);
                chk("release_stall", 64'(mem_stall), 64'd0);
                @(posedge clk); #1;
            end
            set_exp(1'b1, ir, npc, addr, res, rd, {1'b0, is_ld && err, 1'b0, is_st && err});
            check_wb("done");
            chk("done_req", 64'(ifc.dmem_req), 64'd0);
        end
        last_mem = wb_mem;
        last_flags = {lam, laf, sam, saf};
        idle();
        chk("req_count", 64'(n_req - req0), 64'(go));
    endtask

    initial begin
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [63:0] addr;
        int          nb;
        int          req0;

        rst_n = 1'b0;
        mem_v = 1'b1; mem_ir = mk_ir(OpLoad, 3'b011, 5'd1); mem_npc = '0; mem_alu = 64'h1000;
        mem_sr2 = '0; mem_drid = '0; wb_stall = 1'b1;
        ifc.dmem_ack = 1'b0; ifc.dmem_err = 1'b0; ifc.dmem_rdata = '0;
        set_exp(1'b0, '0, '0, '0, '0, '0, 4'b0000);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_stall", 64'(mem_stall), 64'd0);
        chk("rst_req", 64'(ifc.dmem_req), 64'd0);
        chk("rst_we", 64'(ifc.dmem_we), 64'd0);
        chk("rst_addr", ifc.dmem_addr, 64'd0);
        check_wb("rst");
        mem_v = 1'b0; wb_stall = 1'b0;
        rst_n = 1'b1;
        idle();

        // LD, two empty WAIT cycles.
        run_op(mk_ir(OpLoad, 3'b011, 5'd3), 64'h1008, 64'd0, 64'hDEADBEEF01234567, 2, 1'b0, 0, 0);
        chk("ld_result", last_mem, 64'hDEADBEEF01234567);
        chk("ld_stall_cycles", 64'(stall_cycles), 64'd3);
        // LB / LBU of 0x80 at byte 3.
        run_op(mk_ir(OpLoad, 3'b000, 5'd4), 64'h1003, 64'd0, 64'h11223344_80AABBCC, 1, 1'b0, 0, 0);
        chk("lb_result", last_mem, 64'hFFFFFFFFFFFFFF80);
        run_op(mk_ir(OpLoad, 3'b100, 5'd4), 64'h1003, 64'd0, 64'h11223344_80AABBCC, 0, 1'b0, 0, 0);
        chk("lbu_result", last_mem, 64'h80);
        // SH at 0x2006.
        run_op(mk_ir(OpStore, 3'b001, 5'd0), 64'h2006, 64'hABCD, 64'd0, 1, 1'b0, 0, 0);
        chk("sh_wstrb", 64'(last_wstrb), 64'hC0);
        chk("sh_wdata_hi", last_wdata >> 48, 64'hABCD);
        chk("sh_addr", last_addr, 64'h2000);
        chk("sh_we", 64'(last_we), 64'd1);
        chk("sh_mem", last_mem, 64'd0);
        // Misaligned LW; SD with error.
        run_op(mk_ir(OpLoad, 3'b010, 5'd5), 64'h1002, 64'd0, 64'd0, 0, 1'b0, 0, 0);
        chk("lw_lam", 64'(last_flags), 64'b1000);
        run_op(mk_ir(OpStore, 3'b011, 5'd0), 64'h3000, 64'h55, 64'd0, 1, 1'b1, 0, 0);
        chk("sd_saf", 64'(last_flags), 64'b0001);
        // LD with WB_STALL over the ACK for 3 cycles, and one stalled in IDLE first.
        run_op(mk_ir(OpLoad, 3'b011, 5'd6), 64'h4010, 64'd0, 64'h0123456789ABCDEF, 1, 1'b0, 3, 0);
        chk("hold_result", last_mem, 64'h0123456789ABCDEF);
        run_op(mk_ir(OpLoad, 3'b101, 5'd7), 64'h4012, 64'd0, 64'hFFFF8001_00000000, 0, 1'b0, 0, 2);
        // Non-access encodings pass through.
        run_op(mk_ir(OpLoad, 3'b111, 5'd8), 64'h4001, 64'd0, 64'd0, 0, 1'b0, 0, 0);
        run_op(mk_ir(OpStore, 3'b110, 5'd0), 64'h4001, 64'd1, 64'd0, 0, 1'b0, 0, 0);

        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 4))
                0, 1:    opc = OpLoad;
                2, 3:    opc = OpStore;
                default: opc = OpAlu;
            endcase
            f3   = 3'($urandom);
            nb   = 1 << f3[1:0];
            addr = {$urandom, $urandom};
            if ($urandom_range(0, 3) != 0) addr = addr & ~64'(nb - 1);
            run_op(mk_ir(opc, f3, 5'($urandom)), addr, {$urandom, $urandom},
                   {$urandom, $urandom}, $urandom_range(0, 3), ($urandom_range(0, 4) == 0),
                   ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0, $urandom_range(0, 1));
        end

        // Reset in the middle of WAIT, then a stray ACK in IDLE.
        mem_v = 1'b1; mem_ir = mk_ir(OpLoad, 3'b011, 5'd9); mem_alu = 64'h5000;
        @(posedge clk); #1;
        chk("rstw_req_before", 64'(ifc.dmem_req), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rstw_req", 64'(ifc.dmem_req), 64'd0);
        chk("rstw_stall", 64'(mem_stall), 64'd0);
        chk("rstw_wb_v", 64'(wb_v), 64'd0);
        mem_v = 1'b0; mem_ir = '0; mem_alu = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        req0 = n_req;
        ifc.dmem_ack = 1'b1; ifc.dmem_rdata = 64'hBAD; ifc.dmem_err = 1'b1;
        @(posedge clk); #1;
        ifc.dmem_ack = 1'b0; ifc.dmem_err = 1'b0;
        set_exp(1'b0, '0, '0, '0, '0, '0, 4'b0000);
        check_wb("stray");
        chk("stray_req", 64'(ifc.dmem_req), 64'd0);
        @(posedge clk); #1;
        chk("stray_req_count", 64'(n_req - req0), 64'd0);
        run_op(mk_ir(OpLoad, 3'b010, 5'd10), 64'h6004, 64'd0, 64'h87654321_00000000, 1, 1'b0, 0, 0);
        chk("post_rst_lw", last_mem, 64'hFFFFFFFF87654321);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/load_store_stage.md
LOAD_STORE_STAGE -- requirements
Module: load_store_stage

Interface
REQ-001 CLK  in  1  sole clock; all state updates on rising edge.
REQ-002 RESET  in  1  asynchronous, active-low reset.
REQ-003 MEM_V, MEM_IR[31:0], MEM_NPC[63:0], MEM_ALU_RESULT[63:0] (effective address), MEM_SR2[63:0] (store data), MEM_DRID[4:0]  in  instruction from execute.
REQ-004 WB_STALL  in  1  writeback cannot accept a new instruction this cycle.
REQ-005 MEM_STALL  out  1  execute shall hold its outputs this cycle.
REQ-006 DMEM_REQ, DMEM_WE  out  1  data-memory request and write enable; DMEM_ADDR[63:0], DMEM_WDATA[63:0], DMEM_WSTRB[7:0]  out.
REQ-007 DMEM_RDATA[63:0], DMEM_ACK, DMEM_ERR  in  memory response; DMEM_ERR is valid only with DMEM_ACK.
REQ-008 WB_V, WB_IR[31:0], WB_NPC[63:0], WB_ALU_RESULT[63:0], WB_MEM_RESULT[63:0], WB_DRID[4:0], MEM_LAM, MEM_LAF, MEM_SAM, MEM_SAF  out  registered writeback pipeline latch and exception flags.

Function
REQ-009 Load = MEM_IR[6:0] 0000011; store = 0100011; size from funct3[1:0] (1/2/4/8 bytes); loads sign-extend if funct3[2]=0, else zero-extend; load funct3 111 and store funct3[2]=1 pass through with no access.
REQ-010 Misaligned = address not a multiple of the access size; sets MEM_LAM (load) or MEM_SAM (store); no DMEM request issues; the instruction passes through like a non-memory op.
REQ-011 DMEM_ADDR = {addr[63:3],3'b000}; DMEM_WSTRB = size mask shifted left by addr[2:0]; DMEM_WDATA = MEM_SR2 shifted left by 8*addr[2:0].
REQ-012 Load result = DMEM_RDATA shifted right by 8*addr[2:0], truncated to size, then extended per REQ-009.
REQ-013 FSM states: IDLE, WAIT, HOLD.
REQ-014 IDLE, with MEM_V=1, an aligned memory op, and WB_STALL=0:
- set DMEM_REQ=1 next edge, with address/strobe/data/WE registered;
- go to WAIT;
- MEM_STALL=1 combinationally.
REQ-015 IDLE, any other input with WB_STALL=0: next edge WB latch loads the input (WB_V<=MEM_V, WB_MEM_RESULT<=0, flags per REQ-010); MEM_STALL=0.
REQ-016 IDLE with WB_STALL=1: WB latch holds; MEM_STALL=1; no request is issued.
REQ-017 WAIT: DMEM_REQ and all DMEM outputs stay stable until DMEM_ACK; MEM_STALL = !(DMEM_ACK & !WB_STALL).
REQ-018 WAIT with DMEM_ACK=1 and WB_STALL=0: next edge WB latch loads the instruction, load data, and MEM_LAF/MEM_SAF=DMEM_ERR; DMEM_REQ<=0; go to IDLE.
REQ-019 WAIT with DMEM_ACK=1 and WB_STALL=1: capture the result and error into a hold buffer; DMEM_REQ<=0; go to HOLD.
REQ-020 HOLD: MEM_STALL=WB_STALL; on the first cycle with WB_STALL=0, the WB latch loads from the hold buffer; go to IDLE.
REQ-021 On DMEM_ERR, WB_MEM_RESULT=0; a store never updates WB_MEM_RESULT (stays 0).
REQ-022 At most one outstanding request; an instruction is never issued twice.
REQ-023 Load latency: 1 issue cycle plus memory cycles until DMEM_ACK; the WB latch updates on the ACK edge.

Reset
REQ-024 With RESET low: state=IDLE; DMEM_REQ, DMEM_WE, WB_V, and all flags = 0; all data outputs = 0; MEM_STALL=0.
REQ-025 Reset mid-WAIT or mid-HOLD aborts the access; a late DMEM_ACK in IDLE with no request outstanding is ignored.

Verification
REQ-026 LD, addr 0x1008, ACK after 2 cycles with RDATA 0xDEADBEEF_01234567 -> WB_MEM_RESULT=0xDEADBEEF01234567, WB_V=1, MEM_STALL high 3 cycles.
REQ-027 LB, addr 0x1003, RDATA byte3=0x80 -> WB_MEM_RESULT=0xFFFFFFFFFFFFFF80; LBU on the same data -> 0x80.
REQ-028 SH, addr 0x2006, SR2=0xABCD -> DMEM_WSTRB=0xC0, DMEM_WDATA[63:48]=0xABCD, DMEM_ADDR=0x2000, DMEM_WE=1.
REQ-029 LW at 0x1002 -> MEM_LAM=1, no DMEM_REQ, MEM_STALL=0; SD with DMEM_ERR+ACK -> MEM_SAF=1.
REQ-030 WB_STALL asserted during WAIT, ACK arrives, WB_STALL held 3 cycles -> HOLD entered, WB latch unchanged until release, then correct data, single request.
REQ-031 RESET low during WAIT -> DMEM_REQ=0 immediately; after release, state is IDLE and a stray ACK causes no WB_V.
